opt_gen: RTL and testbench

- Per-replica proposal generator: drives the `opt_t` stream that each replica's metropolis stage latches on `opt_run`.
- Draws random K, L, r_metropolis, r_exchange and the move type (two-opt / or-opt) from a private xorshift32 generator.
- Holds one ready proposal in a single-entry buffer. When `opt_run` arrives with no proposal ready, it emits a null (THR) bubble.
- One instance per replica, upstream of the metropolis/exchange pipeline.

---
 rtl/replica_pkg.sv | 40 ++++
 rtl/opt_gen_if.sv | 27 ++
 rtl/xorshift32.sv | 25 ++
 rtl/opt_gen.sv | 135 +++++++++++++
 tb/tb_opt_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/replica_pkg.sv
// Shared replica types: proposal command/struct, generator FSM states, city count.
// Also hosts the xorshift32 step so every random source agrees on the sequence.
package replica_pkg;

  localparam int city_num = 30;
  localparam int city_w   = $clog2(city_num);

  typedef enum logic [1:0] {
    THR = 2'd0,
    TWO = 2'd1,
    OR0 = 2'd2,
    OR1 = 2'd3
  } opt_command_t;

  typedef struct packed {
    opt_command_t        com;
    logic [city_w-1:0]   K;
    logic [city_w-1:0]   L;
    logic [22:0]         r_metropolis;
    logic [22:0]         r_exchange;
  } opt_t;

  typedef enum logic [2:0] {
    DRAW_K = 3'd0,
    DRAW_L = 3'd1,
    DRAW_M = 3'd2,
    DRAW_X = 3'd3,
    FULL   = 3'd4
  } opt_gen_state_t;

  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/opt_gen_if.sv
// Proposal stream between one opt_gen and its replica's metropolis stage.
// master = generator side, slave = consumer side.
interface opt_gen_if;

  logic                run_en;
  logic                opt_run;
  replica_pkg::opt_t   out_opt;
  logic                ready;
  logic [15:0]         bubble_count;

  modport master (
    input  run_en,
    input  opt_run,
    output out_opt,
    output ready,
    output bubble_count
  );

  modport slave (
    output run_en,
    output opt_run,
    input  out_opt,
    input  ready,
    input  bubble_count
  );

endinterface

// File: rtl/xorshift32.sv
// xorshift32 random source: value is the current state, advanced once per cycle when step=1.
// A zero seed is replaced by 1 since zero is a fixed point of the generator.
module xorshift32
  import replica_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] r_x;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      r_x <= xorshift32_next(r_x);
    end
  end

  assign value = r_x;

endmodule

// File: rtl/opt_gen.sv
// Per-replica proposal generator: draws K, L, r_metropolis, r_exchange, move type into a one-entry
// buffer (best case 4 cycles to ready); opt_run consumes it, or yields a THR bubble when not ready.
module opt_gen
  import replica_pkg::*;
#(
  parameter int          id       = 0,
  parameter logic [31:0] seed     = 32'h1,
  parameter int          city_num = replica_pkg::city_num
) (
  input logic        clk,
  input logic        reset,
  opt_gen_if.master  bus
);

  localparam int                CW        = $clog2(city_num);
  localparam logic [city_w-1:0] C_MAX     = city_w'(city_num - 1);
  localparam logic [31:0]       SEED_MIX  = seed ^ (32'(id) * 32'h9E3779B9);
  localparam logic [31:0]       SEED_INIT = (SEED_MIX == 32'h0) ? 32'h1 : SEED_MIX;
  localparam opt_t              THR_OPT   = '{com: THR, K: '0, L: '0,
                                              r_metropolis: '0, r_exchange: '0};

  opt_gen_state_t     r_state;
  opt_gen_state_t     w_state_nxt;
  logic [city_w-1:0]  r_k_buf;
  logic [city_w-1:0]  r_l_buf;
  logic [22:0]        r_met_buf;
  logic [22:0]        r_ex_buf;
  opt_command_t       r_com_buf;
  opt_t               r_out;
  logic [15:0]        r_bubble;

  logic               w_run_en;
  logic               w_opt_run;
  logic               w_step;
  logic [31:0]        w_rng;
  logic [city_w-1:0]  w_c;
  logic               w_c_ok;
  logic               w_ld_k;
  logic               w_ld_l;
  logic               w_ld_m;
  logic               w_ld_x;
  opt_t               w_buf;
  logic               w_unused_rng;

  assign w_run_en     = bus.run_en;
  assign w_opt_run    = bus.opt_run;
  assign w_step       = w_run_en && (r_state != FULL);
  assign w_c          = city_w'(w_rng[CW-1:0]);
  assign w_c_ok       = (w_c != '0) && (w_c <= C_MAX);
  assign w_unused_rng = ^w_rng[30:23];

  xorshift32 u_rng (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_INIT),
    .step  (w_step),
    .value (w_rng)
  );

  // Out-of-range or duplicate candidates are rejected and redrawn next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_k      = 1'b0;
    w_ld_l      = 1'b0;
    w_ld_m      = 1'b0;
    w_ld_x      = 1'b0;
    case (r_state)
      DRAW_K: if (w_run_en && w_c_ok) begin
        w_ld_k      = 1'b1;
        w_state_nxt = DRAW_L;
      end
      DRAW_L: if (w_run_en && w_c_ok && (w_c != r_k_buf)) begin
        w_ld_l      = 1'b1;
        w_state_nxt = DRAW_M;
      end
      DRAW_M: if (w_run_en) begin
        w_ld_m      = 1'b1;
        w_state_nxt = DRAW_X;
      end
      DRAW_X: if (w_run_en) begin
        w_ld_x      = 1'b1;
        w_state_nxt = FULL;
      end
      FULL:    if (w_opt_run) w_state_nxt = DRAW_K;
      default: w_state_nxt = DRAW_K;
    endcase
  end

  assign w_buf = '{com: r_com_buf, K: r_k_buf, L: r_l_buf,
                   r_metropolis: r_met_buf, r_exchange: r_ex_buf};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= DRAW_K;
      r_k_buf   <= '0;
      r_l_buf   <= '0;
      r_met_buf <= '0;
      r_ex_buf  <= '0;
      r_com_buf <= THR;
      r_out     <= THR_OPT;
      r_bubble  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_k) r_k_buf <= w_c;
      if (w_ld_l) r_l_buf <= w_c;
      if (w_ld_m) r_met_buf <= w_rng[22:0];
      if (w_ld_x) begin
        r_ex_buf <= w_rng[22:0];
        // OR0 keeps draw order: downstream derives OR0/OR1 from K<L.
        if (w_rng[31]) begin
          r_com_buf <= TWO;
          if (r_k_buf > r_l_buf) begin
            r_k_buf <= r_l_buf;
            r_l_buf <= r_k_buf;
          end
        end else begin
          r_com_buf <= OR0;
        end
      end
      if (w_opt_run) begin
        if (r_state == FULL) begin
          r_out <= w_buf;
        end else begin
          r_out <= THR_OPT;
          if (w_run_en && (r_bubble != 16'hFFFF)) r_bubble <= r_bubble + 16'd1;
        end
      end
    end
  end

  assign bus.out_opt      = r_out;
  assign bus.ready        = (r_state == FULL);
  assign bus.bubble_count = r_bubble;

endmodule

// File: tb/tb_opt_gen.sv
// Directed bench for opt_gen (city_num=30, seed=1, id=0); inputs driven and outputs sampled on negedge.
module tb_opt_gen;
  import replica_pkg::*;

  logic        clk;
  logic        reset;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] mrng;

  opt_gen_if bus();

  opt_gen #(.id(0), .seed(32'h1), .city_num(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.run_en = 1'b1;
    bus.opt_run = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic strobe();
    bus.opt_run = 1'b1;
    step(1);
    bus.opt_run = 1'b0;
  endtask

  // Reference proposal drawn straight from the xorshift sequence by rejection loops.
  task automatic model_next(output opt_t e);
    logic [4:0] c;
    e = '0;
    do begin c = mrng[4:0]; mrng = xs(mrng); end while (c == 0 || c > 29);
    e.K = c;
    do begin c = mrng[4:0]; mrng = xs(mrng); end while (c == 0 || c > 29 || c == e.K);
    e.L = c;
    e.r_metropolis = mrng[22:0];
    mrng = xs(mrng);
    e.r_exchange = mrng[22:0];
    if (mrng[31]) begin
      e.com = TWO;
      if (e.K > e.L) begin c = e.K; e.K = e.L; e.L = c; end
    end else begin
      e.com = OR0;
    end
    mrng = xs(mrng);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.run_en = 1'b1;
    bus.opt_run = 1'b1;
    step(2);
    bus.opt_run = 1'b0;
    checks++; if (bus.out_opt.com !== THR) $display("FAIL reset_com: got %0d expected %0d", bus.out_opt.com, THR); else passes++;
    checks++; if (bus.out_opt.K !== 5'd0 || bus.out_opt.L !== 5'd0) $display("FAIL reset_KL: got %0d/%0d expected 0/0", bus.out_opt.K, bus.out_opt.L); else passes++;
    checks++; if (bus.out_opt.r_metropolis !== 23'd0 || bus.out_opt.r_exchange !== 23'd0) $display("FAIL reset_r: got %h/%h expected 0/0", bus.out_opt.r_metropolis, bus.out_opt.r_exchange); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.ready); else passes++;
    checks++; if (bus.bubble_count !== 16'd0) $display("FAIL reset_bubble: got %0d expected 0", bus.bubble_count); else passes++;
  endtask

  // Seed 1: w=1 (K=1), 0x00042021 and 0x04080601 (c=1=K, rejected), 0x9DCCA8C5 (L=5),
  // 0x1255994F (r_met=0x55994F), 0x8EF917D1 (bit31 -> TWO, r_ex=0x7917D1): ready after 6 edges.
  task automatic test_first_proposal();
    int n;
    do_reset();
    strobe();
    checks++; if (bus.out_opt.com !== THR) $display("FAIL early_bubble_com: got %0d expected %0d", bus.out_opt.com, THR); else passes++;
    checks++; if (bus.bubble_count !== 16'd1) $display("FAIL early_bubble_count: got %0d expected 1", bus.bubble_count); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL early_ready: got %b expected 0", bus.ready); else passes++;
    wait_ready(40, n);
    checks++; if (n !== 5) $display("FAIL first_latency: got %0d edges expected 5 more (6 total)", n); else passes++;
    checks++; if (bus.out_opt.com !== THR) $display("FAIL hold_between_strobes: got %0d expected %0d", bus.out_opt.com, THR); else passes++;
    strobe();
    checks++; if (bus.out_opt.com !== TWO) $display("FAIL first_com: got %0d expected %0d", bus.out_opt.com, TWO); else passes++;
    checks++; if (bus.out_opt.K !== 5'd1 || bus.out_opt.L !== 5'd5) $display("FAIL first_KL: got %0d/%0d expected 1/5", bus.out_opt.K, bus.out_opt.L); else passes++;
    checks++; if (bus.out_opt.r_metropolis !== 23'h55994F) $display("FAIL first_rmet: got %h expected 55994f", bus.out_opt.r_metropolis); else passes++;
    checks++; if (bus.out_opt.r_exchange !== 23'h7917D1) $display("FAIL first_rex: got %h expected 7917d1", bus.out_opt.r_exchange); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL consume_ready: got %b expected 0", bus.ready); else passes++;
    checks++; if (bus.bubble_count !== 16'd1) $display("FAIL consume_no_count: got %0d expected 1", bus.bubble_count); else passes++;
  endtask

  task automatic test_collision();
    do_reset();
    step(5);
    strobe();
    checks++; if (bus.out_opt.com !== THR) $display("FAIL collide_com: got %0d expected %0d", bus.out_opt.com, THR); else passes++;
    checks++; if (bus.bubble_count !== 16'd1) $display("FAIL collide_bubble: got %0d expected 1", bus.bubble_count); else passes++;
    checks++; if (bus.ready !== 1'b1) $display("FAIL collide_ready: got %b expected 1", bus.ready); else passes++;
    strobe();
    checks++; if (bus.out_opt.com !== TWO || bus.out_opt.K !== 5'd1 || bus.out_opt.L !== 5'd5) $display("FAIL collide_deliver: got com=%0d K=%0d L=%0d expected com=%0d K=1 L=5", bus.out_opt.com, bus.out_opt.K, bus.out_opt.L, TWO); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL collide_consumed: got %b expected 0", bus.ready); else passes++;
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    step(2);
    bus.run_en = 1'b0;
    strobe();
    checks++; if (bus.out_opt.com !== THR) $display("FAIL pause_com: got %0d expected %0d", bus.out_opt.com, THR); else passes++;
    checks++; if (bus.bubble_count !== 16'd0) $display("FAIL pause_no_count: got %0d expected 0", bus.bubble_count); else passes++;
    step(4);
    checks++; if (bus.ready !== 1'b0) $display("FAIL pause_frozen: got %b expected 0", bus.ready); else passes++;
    bus.run_en = 1'b1;
    wait_ready(40, n);
    checks++; if (n !== 4) $display("FAIL pause_resume_latency: got %0d edges expected 4", n); else passes++;
    bus.run_en = 1'b0;
    strobe();
    checks++; if (bus.out_opt.K !== 5'd1 || bus.out_opt.L !== 5'd5 || bus.out_opt.r_exchange !== 23'h7917D1) $display("FAIL pause_no_skip: got K=%0d L=%0d rex=%h expected K=1 L=5 rex=7917d1", bus.out_opt.K, bus.out_opt.L, bus.out_opt.r_exchange); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL pause_consume: got %b expected 0", bus.ready); else passes++;
    step(3);
    checks++; if (bus.ready !== 1'b0) $display("FAIL pause_no_draw: got %b expected 0", bus.ready); else passes++;
    bus.run_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    strobe();
    wait_ready(40, n);
    strobe();
    step(2);
    reset = 1'b0;
    step(1);
    checks++; if (bus.out_opt.com !== THR || bus.out_opt.K !== 5'd0) $display("FAIL midreset_out: got com=%0d K=%0d expected com=%0d K=0", bus.out_opt.com, bus.out_opt.K, THR); else passes++;
    checks++; if (bus.bubble_count !== 16'd0) $display("FAIL midreset_bubble: got %0d expected 0", bus.bubble_count); else passes++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL midreset_ready: got %b expected 0", bus.ready); else passes++;
    reset = 1'b1;
    wait_ready(40, n);
    checks++; if (n !== 6) $display("FAIL midreset_latency: got %0d edges expected 6", n); else passes++;
    strobe();
    checks++; if (bus.out_opt.K !== 5'd1 || bus.out_opt.L !== 5'd5 || bus.out_opt.r_exchange !== 23'h7917D1) $display("FAIL midreset_reseed: got K=%0d L=%0d rex=%h expected K=1 L=5 rex=7917d1", bus.out_opt.K, bus.out_opt.L, bus.out_opt.r_exchange); else passes++;
  endtask

  task automatic test_stream();
    int   n;
    int   twos;
    opt_t e;
    do_reset();
    mrng = 32'h1;
    twos = 0;
    for (int p = 0; p < 1000; p++) begin
      wait_ready(64, n);
      if (bus.ready !== 1'b1) begin
        checks++;
        $display("FAIL stream_timeout: proposal %0d ready=%b expected 1 within 64 cycles", p, bus.ready);
        break;
      end
      model_next(e);
      strobe();
      checks++; if (bus.out_opt !== e) $display("FAIL stream_value: proposal %0d got %h expected %h", p, bus.out_opt, e); else passes++;
      checks++;
      if (bus.out_opt.com === THR || bus.out_opt.K === bus.out_opt.L ||
          bus.out_opt.K == 0 || bus.out_opt.K > 29 || bus.out_opt.L == 0 || bus.out_opt.L > 29 ||
          (bus.out_opt.com === TWO && bus.out_opt.K >= bus.out_opt.L))
        $display("FAIL stream_invariant: proposal %0d got com=%0d K=%0d L=%0d", p, bus.out_opt.com, bus.out_opt.K, bus.out_opt.L);
      else passes++;
      if (bus.out_opt.com === TWO) twos++;
    end
    checks++; if (twos < 440 || twos > 560) $display("FAIL stream_two_ratio: got %0d TWO of 1000 expected 440..560", twos); else passes++;
    checks++; if (bus.bubble_count !== 16'd0) $display("FAIL stream_bubbles: got %0d expected 0", bus.bubble_count); else passes++;
  endtask

  initial begin
    reset = 1'b0;
    bus.run_en = 1'b0;
    bus.opt_run = 1'b0;
    test_reset();
    test_first_proposal();
    test_collision();
    test_pause();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
